// File: rtl/coloring_pkg.sv
// Shared types and width helpers for the graph colouring checker.
package coloring_pkg;

    // Widest vertex index the edge record can carry; the store keeps only the bits in use.
    localparam int MAX_VW = 8;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} chk_state_e;

    typedef struct packed {
        logic [MAX_VW-1:0] u;
        logic [MAX_VW-1:0] v;
    } edge_t;

    function automatic int width_of(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/graph_coloring_checker_edge_store.sv
// Edge list RAM: one write port, one registered read port, write-first on address collision.
module edge_store #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        // A write and a read of the same edge in one cycle must return the new edge.
        if (we && (waddr == raddr)) begin
            rdata <= wdata;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/graph_coloring_checker.sv
// Sequential proper-colouring checker: scans a programmable edge list one edge per cycle
// against a registered candidate colouring and reports conflict count and first conflict.
module graph_coloring_checker
    import coloring_pkg::*;
#(
    parameter  int NUM_VERTICES = 6,
    parameter  int COLOR_BITS   = 2,
    parameter  int MAX_EDGES    = 16,
    localparam int VW = width_of(NUM_VERTICES),
    localparam int EW = width_of(MAX_EDGES),
    localparam int CW = width_of(MAX_EDGES + 1)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               cfg_we,
    input  logic [EW-1:0]                      cfg_addr,
    input  logic [VW-1:0]                      cfg_u,
    input  logic [VW-1:0]                      cfg_v,
    input  logic [CW-1:0]                      cfg_num_edges,
    output logic                               cfg_ready,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [NUM_VERTICES*COLOR_BITS-1:0] in_colors,
    input  logic [COLOR_BITS-1:0]              in_max_color,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               out_proper,
    output logic [CW-1:0]                      out_conflicts,
    output logic [EW-1:0]                      out_first,
    output logic                               out_range_err
);

    chk_state_e                         state_reg;
    logic [NUM_VERTICES*COLOR_BITS-1:0] colors_reg;
    logic [CW-1:0]                      n_reg, count_reg, count_next, n_clamped;
    logic [EW-1:0]                      e_reg, first_reg, first_next, raddr;
    logic                               found_reg, found_next, range_reg;
    logic                               accept, wr_en, conflict, last_edge, range_now;
    logic [2*VW-1:0]                    rdata;
    edge_t                              cur_edge;
    logic [COLOR_BITS-1:0]              color_arr [2**VW];
    logic [NUM_VERTICES-1:0]            over_max;

    // Padding the colour table to a power of two keeps every vertex index in range.
    for (genvar gi = 0; gi < 2**VW; gi++) begin : g_color
        if (gi < NUM_VERTICES) begin : g_real
            assign color_arr[gi] = colors_reg[gi*COLOR_BITS +: COLOR_BITS];
        end else begin : g_pad
            assign color_arr[gi] = '0;
        end
    end

    for (genvar gi = 0; gi < NUM_VERTICES; gi++) begin : g_range
        assign over_max[gi] = in_colors[gi*COLOR_BITS +: COLOR_BITS] > in_max_color;
    end

    assign range_now = |over_max;
    assign accept    = in_valid && in_ready;
    assign wr_en     = cfg_we && (state_reg == IDLE);
    assign n_clamped = (cfg_num_edges > CW'(MAX_EDGES)) ? CW'(MAX_EDGES) : cfg_num_edges;
    // Prefetch edge e+1 while edge e is compared; IDLE primes edge 0.
    assign raddr     = (state_reg == SCAN) ? e_reg + EW'(1) : '0;
    assign last_edge = (CW'(e_reg) + CW'(1)) == n_reg;

    edge_store #(
        .DEPTH(MAX_EDGES),
        .AW   (EW),
        .DW   (2*VW)
    ) u_edge_store (
        .clk  (clk),
        .we   (wr_en),
        .waddr(cfg_addr),
        .wdata({cfg_u, cfg_v}),
        .raddr(raddr),
        .rdata(rdata)
    );

    always_comb begin
        cur_edge.u = MAX_VW'(rdata[2*VW-1:VW]);
        cur_edge.v = MAX_VW'(rdata[VW-1:0]);
        conflict   = (cur_edge.u >= MAX_VW'(NUM_VERTICES)) ||
                     (cur_edge.v >= MAX_VW'(NUM_VERTICES)) ||
                     (cur_edge.u == cur_edge.v) ||
                     (color_arr[cur_edge.u[VW-1:0]] == color_arr[cur_edge.v[VW-1:0]]);
        count_next = count_reg + CW'(conflict);
        first_next = (conflict && !found_reg) ? e_reg : first_reg;
        found_next = found_reg || conflict;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cfg_ready     <= 1'b1;
            in_ready      <= 1'b1;
            out_valid     <= 1'b0;
            out_proper    <= 1'b0;
            out_conflicts <= '0;
            out_first     <= '0;
            out_range_err <= 1'b0;
            colors_reg    <= '0;
            n_reg         <= '0;
            count_reg     <= '0;
            first_reg     <= '0;
            found_reg     <= 1'b0;
            range_reg     <= 1'b0;
            e_reg         <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        colors_reg <= in_colors;
                        n_reg      <= n_clamped;
                        range_reg  <= range_now;
                        count_reg  <= '0;
                        first_reg  <= '0;
                        found_reg  <= 1'b0;
                        e_reg      <= '0;
                        in_ready   <= 1'b0;
                        cfg_ready  <= 1'b0;
                        if (n_clamped == '0) begin
                            state_reg     <= DONE;
                            out_valid     <= 1'b1;
                            out_proper    <= !range_now;
                            out_conflicts <= '0;
                            out_first     <= '0;
                            out_range_err <= range_now;
                        end else begin
                            state_reg <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    count_reg <= count_next;
                    first_reg <= first_next;
                    found_reg <= found_next;
                    e_reg     <= e_reg + EW'(1);
                    if (last_edge) begin
                        state_reg     <= DONE;
                        out_valid     <= 1'b1;
                        out_proper    <= (count_next == '0) && !range_reg;
                        out_conflicts <= count_next;
                        out_first     <= first_next;
                        out_range_err <= range_reg;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        cfg_ready <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
